// File: rtl/syncfifo_swc.sv
// Single-clock FIFO: register-array storage, registered read data, wrap-bit pointers.
// Define SYNCFIFO_SWC_ALMOST_EN to add almost_full/almost_empty outputs backed by an occupancy counter.
module syncfifo_swc #(
    parameter int DATA_WIDTH      = 32,
    parameter int ADDR_WIDTH      = 4,
    parameter int DEPTH           = 16,
    parameter int ALMOST_FULL_TH  = 14,
    parameter int ALMOST_EMPTY_TH = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  wen,
    input  logic [DATA_WIDTH-1:0] wdata,
    output logic                  full,
    input  logic                  ren,
    output logic [DATA_WIDTH-1:0] rdata,
    output logic                  empty
`ifdef SYNCFIFO_SWC_ALMOST_EN
    ,
    output logic                  almost_full,
    output logic                  almost_empty
`endif
);

    localparam logic [ADDR_WIDTH:0] PTR_ONE = 1;

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];
    logic [ADDR_WIDTH:0]   wptr_q, wptr_d;
    logic [ADDR_WIDTH:0]   rptr_q, rptr_d;
    logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
    logic                  wr_ok;
    logic                  rd_ok;

    // Same slot index with opposite wrap bits means the writer is a full lap ahead.
    assign empty = (wptr_q == rptr_q);
    assign full  = (wptr_q[ADDR_WIDTH-1:0] == rptr_q[ADDR_WIDTH-1:0]) &&
                   (wptr_q[ADDR_WIDTH] != rptr_q[ADDR_WIDTH]);

    assign wr_ok = wen & ~full;
    assign rd_ok = ren & ~empty;
    assign rdata = rdata_q;

    always_comb begin
        wptr_d  = wptr_q;
        rptr_d  = rptr_q;
        rdata_d = rdata_q;
        if (wr_ok) begin
            wptr_d = wptr_q + PTR_ONE;
        end
        if (rd_ok) begin
            rptr_d  = rptr_q + PTR_ONE;
            rdata_d = mem_q[rptr_q[ADDR_WIDTH-1:0]];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            rdata_q <= '0;
        end else begin
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            rdata_q <= rdata_d;
        end
    end

    // Storage is deliberately left out of reset so it maps onto plain registers/RAM.
    always_ff @(posedge clk) begin
        if (wr_ok) begin
            mem_q[wptr_q[ADDR_WIDTH-1:0]] <= wdata;
        end
    end

`ifdef SYNCFIFO_SWC_ALMOST_EN
    localparam logic [ADDR_WIDTH:0] AF_TH = (ADDR_WIDTH+1)'(ALMOST_FULL_TH);
    localparam logic [ADDR_WIDTH:0] AE_TH = (ADDR_WIDTH+1)'(ALMOST_EMPTY_TH);

    logic [ADDR_WIDTH:0] count_q, count_d;

    always_comb begin
        count_d = count_q;
        case ({wr_ok, rd_ok})
            2'b10:   count_d = count_q + PTR_ONE;
            2'b01:   count_d = count_q - PTR_ONE;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign almost_full  = (count_q >= AF_TH);
    assign almost_empty = (count_q <= AE_TH);
`endif

endmodule

// File: tb/tb_syncfifo_swc.sv
// Directed bench for syncfifo_swc; a queue scoreboard predicts read data and flags.
module tb_syncfifo_swc;

    localparam int DW    = 32;
    localparam int DEPTH = 16;

    logic          clk = 1'b0;
    logic          rst;
    logic          wen;
    logic [DW-1:0] wdata;
    logic          full;
    logic          ren;
    logic [DW-1:0] rdata;
    logic          empty;
`ifdef SYNCFIFO_SWC_ALMOST_EN
    logic          almost_full;
    logic          almost_empty;
`endif

    syncfifo_swc dut (
        .clk   (clk),
        .rst   (rst),
        .wen   (wen),
        .wdata (wdata),
        .full  (full),
        .ren   (ren),
        .rdata (rdata),
        .empty (empty)
`ifdef SYNCFIFO_SWC_ALMOST_EN
        ,
        .almost_full  (almost_full),
        .almost_empty (almost_empty)
`endif
    );

    always #5 clk = ~clk;

    int            checks = 0;
    int            errors = 0;
    logic [DW-1:0] sb [$];
    logic [DW-1:0] exp_rdata = '0;
    logic          last_wr;
    logic [DW-1:0] wcnt;

    task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic check_state(input string ph);
        check({ph, ".rdata"}, rdata, exp_rdata);
        check({ph, ".empty"}, DW'(empty), DW'(sb.size() == 0));
        check({ph, ".full"},  DW'(full),  DW'(sb.size() == DEPTH));
`ifdef SYNCFIFO_SWC_ALMOST_EN
        check({ph, ".almost_full"},  DW'(almost_full),  DW'(sb.size() >= 14));
        check({ph, ".almost_empty"}, DW'(almost_empty), DW'(sb.size() <= 2));
`endif
    endtask

    // One clock: drive request, predict acceptance from pre-edge occupancy, check after the edge.
    task automatic step(input string ph, input logic w, input logic r, input logic [DW-1:0] d);
        logic wr_ok;
        logic rd_ok;
        wr_ok = w && (sb.size() < DEPTH);
        rd_ok = r && (sb.size() > 0);
        wen   = w;
        ren   = r;
        wdata = d;
        @(posedge clk);
        #1;
        if (rd_ok) exp_rdata = sb.pop_front();
        if (wr_ok) sb.push_back(d);
        last_wr = wr_ok;
        $display("%s: wen=%0b ren=%0b wdata=%h -> rdata=%h empty=%0b full=%0b occ=%0d",
                 ph, w, r, d, rdata, empty, full, sb.size());
        check_state(ph);
    endtask

    initial begin
        rst = 1'b1; wen = 1'b0; ren = 1'b0; wdata = '0;
        repeat (10) @(posedge clk);
        #1;
        check_state("reset");

        // Partial fill, one read, then an asynchronous reset between edges.
        rst = 1'b0;
        for (int i = 0; i < 5; i++) step("prefill", 1'b1, 1'b0, DW'(32'hA0 + i));
        step("preread", 1'b0, 1'b1, '0);
        #2;
        rst = 1'b1;
        #1;
        sb.delete();
        exp_rdata = '0;
        check("async_rst.empty", DW'(empty), DW'(1));
        check("async_rst.full",  DW'(full),  DW'(0));
        check("async_rst.rdata", rdata, '0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        check_state("post_rst");

        // Fill past capacity; data only advances on accepted writes.
        wcnt = '0;
        for (int i = 0; i < 20; i++) begin
            step("fill", 1'b1, 1'b0, wcnt);
            if (last_wr) wcnt++;
        end

        // Drain past empty; rdata must hold the last word.
        for (int i = 0; i < 20; i++) step("drain", 1'b0, 1'b1, '0);

        // Empty + both requests: write only, rdata unchanged.
        step("empty_wr_rd", 1'b1, 1'b1, 32'h0000_0100);

        for (int i = 0; i < 7; i++) step("to8", 1'b1, 1'b0, DW'(32'h200 + i));

        // Steady state across several pointer wraps.
        for (int i = 0; i < 40; i++) step("concurrent", 1'b1, 1'b1, $urandom);

        for (int i = 0; i < 8; i++) step("to_full", 1'b1, 1'b0, DW'(32'h300 + i));

        // Full + both requests: read only, full drops.
        step("full_wr_rd", 1'b1, 1'b1, 32'hDEAD_BEEF);
        step("refill", 1'b1, 1'b0, 32'h0000_0400);

        for (int i = 0; i < 18; i++) step("final_drain", 1'b0, 1'b1, '0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
